// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   imm_kind_t : format tag carried with every decoded immediate
//   OP_*       : RV32/RV64 major opcodes recognised by the decoder
//   imm_res_t  : full-width (RV64) decode record {imm, kind, illegal, pc};
//                narrower datapaths keep the low XLEN bits of imm/pc.
package imm_gen_pkg;

  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_CSR   = 3'd7
  } imm_kind_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R32    = 7'b0111011;

  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    imm_kind_t           kind;
    logic                illegal;
    logic [MAX_XLEN-1:0] pc;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// Pure combinational immediate decoder.
//   inst    : 32-bit instruction word
//   imm     : sign/zero-extended immediate, XLEN bits
//   kind    : format tag (imm_kind_t)
//   illegal : opcode not present in the decode table
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_RV64  = (XLEN == 64),
  parameter bit          EN_ZICSR = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_kind_t       kind,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    imm     = '0;
    kind    = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        imm  = XLEN'($signed(inst[31:20]));
        kind = IMM_I;
      end
      OP_IMM: begin
        // slli/srli/srai carry a shift amount, not a signed immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (XLEN == 64) imm = XLEN'(inst[25:20]);
          else            imm = XLEN'(inst[24:20]);
          kind = IMM_SHAMT;
        end else begin
          imm  = XLEN'($signed(inst[31:20]));
          kind = IMM_I;
        end
      end
      OP_IMM32: begin
        if (EN_RV64) begin
          imm  = XLEN'(inst[24:20]);
          kind = IMM_SHAMT;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
        kind = IMM_S;
      end
      OP_BRANCH: begin
        imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        kind = IMM_B;
      end
      OP_JAL: begin
        imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        kind = IMM_J;
      end
      OP_LUI, OP_AUIPC: begin
        imm  = XLEN'($signed({inst[31:12], 12'b0}));
        kind = IMM_U;
      end
      OP_SYSTEM: begin
        // ecall/ebreak/xret (funct3==000) carry no immediate
        if (EN_ZICSR && funct3 != 3'b000) begin
          imm  = XLEN'(inst[19:15]);
          kind = IMM_CSR;
        end
      end
      OP_R, OP_R32: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous discard of all held entries
//   in_valid/in_ready     : input handshake; in_inst, in_pc payload
//   out_valid/out_ready   : output handshake
//   out_imm/out_kind/out_illegal/out_pc : decoded result of one instruction
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_RV64  = (XLEN == 64),
  parameter bit          EN_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_kind_t       out_kind,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_kind_t       kind;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  skid_state_t     state;
  entry_t          main_q, skid_q, dec;
  logic [XLEN-1:0] dec_imm;
  imm_kind_t       dec_kind;
  logic            dec_illegal;
  logic            in_xfer, out_xfer;

  imm_decode #(
    .XLEN     (XLEN),
    .EN_RV64  (EN_RV64),
    .EN_ZICSR (EN_ZICSR)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec         = '0;
    dec.imm     = dec_imm;
    dec.kind    = dec_kind;
    dec.illegal = dec_illegal;
    dec.pc      = in_pc;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // in_ready and out_valid are flops mirroring the state, so neither has a
  // combinational path from the opposite side of the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q   <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_q <= dec;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_imm     = main_q.imm;
  assign out_kind    = main_q.kind;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: an RV32 and an RV64 instance share one stimulus
// stream; a FIFO-occupancy model with an arithmetic decode reference
// predicts every output.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc64 = '0;
  logic [31:0] in_pc32;

  logic        ir32, ov32, il32;
  logic [31:0] imm32, pc32;
  imm_kind_t   k32;
  logic        ir64, ov64, il64;
  logic [63:0] imm64, pc64;
  imm_kind_t   k64;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q_inst[$];
  logic [63:0] q_pc[$];

  assign in_pc32 = in_pc64[31:0];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32), .in_inst(in_inst), .in_pc(in_pc32),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_kind(k32), .out_illegal(il32), .out_pc(pc32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64), .in_inst(in_inst), .in_pc(in_pc64),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_kind(k64), .out_illegal(il64), .out_pc(pc64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    return (v ^ m) - m;
  endfunction

  // Reference decode from the ISA immediate layouts, computed arithmetically.
  function automatic imm_res_t ref_decode(input logic [31:0] inst, input bit rv64);
    imm_res_t r;
    logic [6:0] op;
    logic [2:0] f3;
    op = inst[6:0];
    f3 = inst[14:12];
    r = '0;
    r.kind = IMM_NONE;
    if (op == 7'h03 || op == 7'h67 || (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5)) begin
      r.imm = sext(64'(inst[31:20]), 12); r.kind = IMM_I;
    end else if (op == 7'h13) begin
      r.imm = rv64 ? 64'(inst[25:20]) : 64'(inst[24:20]); r.kind = IMM_SHAMT;
    end else if (op == 7'h1B) begin
      if (rv64) begin r.imm = 64'(inst[24:20]); r.kind = IMM_SHAMT; end
      else r.illegal = 1'b1;
    end else if (op == 7'h23) begin
      r.imm = sext(64'(inst[31:25]) * 32 + 64'(inst[11:7]), 12); r.kind = IMM_S;
    end else if (op == 7'h63) begin
      r.imm = sext(64'(inst[31]) * 4096 + 64'(inst[7]) * 2048 +
                   64'(inst[30:25]) * 32 + 64'(inst[11:8]) * 2, 13);
      r.kind = IMM_B;
    end else if (op == 7'h6F) begin
      r.imm = sext(64'(inst[31]) * (64'd1 << 20) + 64'(inst[19:12]) * 4096 +
                   64'(inst[20]) * 2048 + 64'(inst[30:21]) * 2, 21);
      r.kind = IMM_J;
    end else if (op == 7'h37 || op == 7'h17) begin
      r.imm = sext(64'(inst[31:12]) * 4096, 32); r.kind = IMM_U;
    end else if (op == 7'h73) begin
      if (f3 != 3'd0) begin r.imm = 64'(inst[19:15]); r.kind = IMM_CSR; end
    end else if (op == 7'h33 || op == 7'h3B) begin
      r.kind = IMM_NONE;
    end else begin
      r.illegal = 1'b1;
    end
    if (!rv64) r.imm = {32'h0, r.imm[31:0]};
    return r;
  endfunction

  task automatic check_model();
    imm_res_t e32, e64;
    chk("in_ready32", 64'(ir32), 64'(q_inst.size() < 2));
    chk("in_ready64", 64'(ir64), 64'(q_inst.size() < 2));
    chk("out_valid32", 64'(ov32), 64'(q_inst.size() != 0));
    chk("out_valid64", 64'(ov64), 64'(q_inst.size() != 0));
    if (q_inst.size() != 0) begin
      e32 = ref_decode(q_inst[0], 1'b0);
      e64 = ref_decode(q_inst[0], 1'b1);
      chk("imm32", 64'(imm32), e32.imm);
      chk("kind32", 64'(k32), 64'(e32.kind));
      chk("illegal32", 64'(il32), 64'(e32.illegal));
      chk("pc32", 64'(pc32), {32'h0, q_pc[0][31:0]});
      chk("imm64", imm64, e64.imm);
      chk("kind64", 64'(k64), 64'(e64.kind));
      chk("illegal64", 64'(il64), 64'(e64.illegal));
      chk("pc64", pc64, q_pc[0]);
    end
  endtask

  // One clock: drive at negedge, update the FIFO model at posedge, check at
  // the following negedge.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    bit in_x, out_x;
    logic [63:0] pcv;
    pcv = {$urandom(), $urandom()};
    in_valid  = v;
    in_inst   = inst;
    in_pc64   = pcv;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    in_x  = v && (q_inst.size() < 2);
    out_x = rdy && (q_inst.size() != 0);
    if (fl) begin
      q_inst.delete();
      q_pc.delete();
    end else begin
      if (out_x) begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      if (in_x) begin
        q_inst.push_back(inst);
        q_pc.push_back(pcv);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov32"}, 64'(ov32), 64'd0);
    chk({tag, "_ov64"}, 64'(ov64), 64'd0);
    chk({tag, "_ir32"}, 64'(ir32), 64'd1);
    chk({tag, "_imm32"}, 64'(imm32), 64'd0);
    chk({tag, "_imm64"}, imm64, 64'd0);
    chk({tag, "_kind64"}, 64'(k64), 64'(IMM_NONE));
    chk({tag, "_ill64"}, 64'(il64), 64'd0);
    chk({tag, "_pc64"}, pc64, 64'd0);
  endtask

  logic [6:0] op_tab[14] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                             7'h37, 7'h17, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h00};

  initial begin
    logic [31:0] r;
    logic        hold_valid;
    logic [63:0] held_imm;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    // addi x1, x0, -1
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_kind32", 64'(k32), 64'(IMM_I));

    // sw / beq / jal back to back
    cycle(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    chk("sw_imm32", 64'(imm32), 64'hFFFF_FFFC);
    cycle(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
    chk("beq_imm32", 64'(imm32), 64'hFFFF_FFF8);
    cycle(1'b1, 32'h001000EF, 1'b1, 1'b0);
    chk("jal_imm32", 64'(imm32), 64'h0000_0800);

    // lui variants and srai with shamt 63
    cycle(1'b1, 32'h123452B7, 1'b1, 1'b0);
    chk("lui_imm64", imm64, 64'h0000_0000_1234_5000);
    cycle(1'b1, 32'h800002B7, 1'b1, 1'b0);
    chk("lui_neg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    cycle(1'b1, 32'h43F0D093, 1'b1, 1'b0);
    chk("srai_imm64", imm64, 64'h3F);
    chk("srai_kind64", 64'(k64), 64'(IMM_SHAMT));
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure: three offered, two accepted, output held stable
    cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
    held_imm = imm64;
    cycle(1'b1, 32'hFFC00193, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(ir32), 64'd0);
    cycle(1'b1, 32'h7FF00213, 1'b0, 1'b0);
    chk("bp_stable_imm", imm64, held_imm);
    cycle(1'b1, 32'h7FF00213, 1'b1, 1'b0);
    cycle(1'b1, 32'h7FF00213, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush while full with a simultaneous input
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300093, 1'b0, 1'b1);
    chk("flush_ov", 64'(ov32), 64'd0);
    chk("flush_ir", 64'(ir64), 64'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // illegal opcode
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("illegal_flag", 64'(il64), 64'd1);
    chk("illegal_imm", imm64, 64'd0);

    // asynchronous reset mid-stream
    cycle(1'b1, 32'h00A00093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B00093, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    q_inst.delete();
    q_pc.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("post_rst_ov", 64'(ov64), 64'd1);

    // randomized traffic
    hold_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            {r[31:7], op_tab[$urandom_range(0, 13)]},
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
